instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
Pipeline stage directly upstream of the operand shifter. It accepts raw 32-bit ARM instruction words from fetch and decodes them into the shifter control fields (opcode, data12, branch offset, immediate flag) plus register addresses and control bits. Results are registered behind a valid/ready handshake, with a 2-entry skid buffer and flush support for taken branches.

Parameters:
PC_WIDTH, 32, width of the program-counter value carried alongside each instruction
ILLEGAL_OPCODE, 5'b11111, opcode emitted for undecodable instructions

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  discard all held and incoming instructions (branch taken)
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept (registered)
in_instr  in  32  raw instruction word
in_pc  in  PC_WIDTH  address of in_instr
out_valid  out  1  decoded fields valid
out_ready  in  1  downstream (shifter/ALU stage) accepts
opcode  out  5  to shifter: 5'b10001 branch, 5'b10000 single data transfer, {1'b0,instr[24:21]} data processing
immediateOperand  out  1  instr[25] (I bit; for data transfer, 0 = immediate offset)
data12  out  12  instr[11:0]
branchOffset  out  24  instr[23:0]
cond  out  4  instr[31:28]
rn_addr, rd_addr, rm_addr  out  4 each  instr[19:16], instr[15:12], instr[3:0]
set_flags  out  1  instr[20] for data processing, else 0
load  out  1  instr[20] for data transfer, else 0
link  out  1  instr[24] for branch, else 0
illegal  out  1  undecodable instruction
out_pc  out  PC_WIDTH  PC of the decoded instruction

Behaviour:
- Decode is combinational on the accepted word. Priority: instr[27:25]==3'b101 -> branch; instr[27:26]==2'b01 -> data transfer; instr[27:26]==2'b00 -> data processing; otherwise, or cond==4'b1111 -> illegal=1, opcode=ILLEGAL_OPCODE, all other control bits 0.
- Storage: main register (drives outputs) plus one skid register, each with a valid bit.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- Latency: accepted word appears on outputs on the next edge when main is empty or draining. Throughput is 1 per cycle under continuous out_ready.
- Accept while main holds a word and out_ready is low: the word goes to skid, and in_ready deasserts on the next edge.
- Main drained while skid is full: skid moves to main on the same edge, and in_ready reasserts on the next edge.
- in_ready = registered !skid_valid. It never depends combinationally on out_ready.
- Order is strictly preserved. There is no duplication or loss under any out_ready pattern.
- flush=1 at an edge: both valid bits clear, in_ready=1, and a word offered in the same cycle is dropped. flush overrides simultaneous accept and transfer-out.
- Reset (async assert, sync release): out_valid=0, skid_valid=0, in_ready=1, all data outputs 0. Reset mid-transfer discards held words.
- Data outputs hold their value while out_valid=1 && out_ready=0, and are don't-care when out_valid=0.

Decomposition:
- Shared package: opcode constants (OPC_BRANCH=5'b10001, OPC_SDT=5'b10000, OPC_ILLEGAL), the instruction-class field positions, and a decoded-instruction packed struct (all output fields) used by this stage and the shifter stage.
- One natural sub-module: instr_decode_comb (pure combinational instruction -> struct). The stage instantiates it on the input side so the skid buffer stores decoded structs.

Test Plan:
- Reset: hold reset_n low for 3 cycles with in_valid=1 -> out_valid=0 and in_ready=1 throughout; first word is accepted on the first edge after release.
- Data processing: 0xE3A01005 (MOV r1,#5), out_ready=1 -> next cycle opcode=5'b01101, immediateOperand=1, rd_addr=1, data12=12'h005, cond=4'hE, illegal=0.
- Load and branch back-to-back: 0xE5912004 then 0xEAFFFFFE -> first gives opcode=5'b10000, immediateOperand=0, load=1, rn=1, rd=2, data12=12'h004; second gives opcode=5'b10001, branchOffset=24'hFFFFFE, link=0. Both appear on consecutive cycles.
- Backpressure: stream PCs 0,4,8,12 with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts; on release, out_pc sequence is 0,4,8,12 with no gaps beyond skid drain and no loss.
- Flush: main and skid full, assert flush with in_valid=1 (pc=0x40) -> next cycle out_valid=0 and in_ready=1; pc 0x40 never appears at the output.
- Illegal: 0xEE000000 and 0xF3A01005 -> illegal=1, opcode=5'b11111, set_flags/load/link=0, still handshaken normally.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions: opcode encodings, ARM instruction field positions,
// and the decoded-instruction record passed from decode to the shifter stage.
package instr_decode_stage_pkg;

    localparam logic [4:0] OPC_BRANCH  = 5'b10001;
    localparam logic [4:0] OPC_SDT     = 5'b10000;
    localparam logic [4:0] OPC_ILLEGAL = 5'b11111;

    localparam int COND_LSB   = 28;
    localparam int CLASS_LSB  = 25;
    localparam int DPOP_LSB   = 21;
    localparam int IBIT_POS   = 25;
    localparam int LINK_POS   = 24;
    localparam int SL_POS     = 20;
    localparam int RN_LSB     = 16;
    localparam int RD_LSB     = 12;
    localparam int RM_LSB     = 0;
    localparam int DATA12_LSB = 0;
    localparam int BOFF_LSB   = 0;

    localparam logic [3:0] COND_NV    = 4'b1111;
    localparam logic [2:0] CLS_BRANCH = 3'b101;
    localparam logic [1:0] CLS_SDT    = 2'b01;
    localparam logic [1:0] CLS_DP     = 2'b00;

    typedef enum logic [1:0] {
        IC_DP,
        IC_SDT,
        IC_BRANCH,
        IC_UNDEF
    } instr_class_e;

    typedef struct packed {
        logic [4:0]  opcode;
        logic        imm;
        logic [11:0] data12;
        logic [23:0] branch_offset;
        logic [3:0]  cond;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic        set_flags;
        logic        load;
        logic        link;
        logic        illegal;
    } decoded_t;

    // Branch is tested before the 2-bit classes because 3'b101 overlaps none of
    // them, but the NV condition makes any class undecodable.
    function automatic instr_class_e classify(input logic [3:0] cond, input logic [2:0] cls);
        if (cond == COND_NV)
            return IC_UNDEF;
        if (cls == CLS_BRANCH)
            return IC_BRANCH;
        if (cls[2:1] == CLS_SDT)
            return IC_SDT;
        if (cls[2:1] == CLS_DP)
            return IC_DP;
        return IC_UNDEF;
    endfunction

endpackage

// File: rtl/instr_decode_stage_comb.sv
// Pure combinational decode of a raw ARM instruction word into a decoded_t.
module instr_decode_comb
    import instr_decode_stage_pkg::*;
#(
    parameter logic [4:0] ILLEGAL_OPCODE = OPC_ILLEGAL
) (
    input  logic [31:0] i_instr,
    output decoded_t    o_dec
);

    instr_class_e w_cls;

    assign w_cls = classify(i_instr[COND_LSB +: 4], i_instr[CLASS_LSB +: 3]);

    always_comb begin
        o_dec               = '0;
        o_dec.data12        = i_instr[DATA12_LSB +: 12];
        o_dec.branch_offset = i_instr[BOFF_LSB +: 24];
        o_dec.cond          = i_instr[COND_LSB +: 4];
        o_dec.rn            = i_instr[RN_LSB +: 4];
        o_dec.rd            = i_instr[RD_LSB +: 4];
        o_dec.rm            = i_instr[RM_LSB +: 4];
        unique case (w_cls)
            IC_BRANCH: begin
                o_dec.opcode = OPC_BRANCH;
                o_dec.imm    = i_instr[IBIT_POS];
                o_dec.link   = i_instr[LINK_POS];
            end
            IC_SDT: begin
                o_dec.opcode = OPC_SDT;
                o_dec.imm    = i_instr[IBIT_POS];
                o_dec.load   = i_instr[SL_POS];
            end
            IC_DP: begin
                o_dec.opcode    = {1'b0, i_instr[DPOP_LSB +: 4]};
                o_dec.imm       = i_instr[IBIT_POS];
                o_dec.set_flags = i_instr[SL_POS];
            end
            default: begin
                o_dec.opcode  = ILLEGAL_OPCODE;
                o_dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: decodes on the input side, then holds results in a main register
// (drives outputs) plus a one-deep skid register behind a valid/ready handshake.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int         PC_WIDTH       = 32,
    parameter logic [4:0] ILLEGAL_OPCODE = OPC_ILLEGAL
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          opcode,
    output logic                immediateOperand,
    output logic [11:0]         data12,
    output logic [23:0]         branchOffset,
    output logic [3:0]          cond,
    output logic [3:0]          rn_addr,
    output logic [3:0]          rd_addr,
    output logic [3:0]          rm_addr,
    output logic                set_flags,
    output logic                load,
    output logic                link,
    output logic                illegal,
    output logic [PC_WIDTH-1:0] out_pc
);

    decoded_t              w_dec;
    logic                  w_accept;
    logic                  w_main_free;

    decoded_t              r_main;
    decoded_t              r_skid;
    logic [PC_WIDTH-1:0]   r_main_pc;
    logic [PC_WIDTH-1:0]   r_skid_pc;
    logic                  r_main_v;
    logic                  r_skid_v;
    logic                  r_in_ready;

    instr_decode_comb #(
        .ILLEGAL_OPCODE (ILLEGAL_OPCODE)
    ) u_decode (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign w_accept    = in_valid && r_in_ready;
    // Main can take a new word when it is empty or its word leaves this edge.
    assign w_main_free = !r_main_v || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_pc  <= '0;
            r_skid_pc  <= '0;
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (w_main_free) begin
            if (r_skid_v) begin
                // in_ready is low while skid is full, so nothing new arrives here.
                r_main     <= r_skid;
                r_main_pc  <= r_skid_pc;
                r_main_v   <= 1'b1;
                r_skid_v   <= 1'b0;
                r_in_ready <= 1'b1;
            end else begin
                r_main_v <= w_accept;
                if (w_accept) begin
                    r_main    <= w_dec;
                    r_main_pc <= in_pc;
                end
            end
        end else if (w_accept) begin
            r_skid     <= w_dec;
            r_skid_pc  <= in_pc;
            r_skid_v   <= 1'b1;
            r_in_ready <= 1'b0;
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = r_main_v;
    assign out_pc           = r_main_pc;
    assign opcode           = r_main.opcode;
    assign immediateOperand = r_main.imm;
    assign data12           = r_main.data12;
    assign branchOffset     = r_main.branch_offset;
    assign cond             = r_main.cond;
    assign rn_addr          = r_main.rn;
    assign rd_addr          = r_main.rd;
    assign rm_addr          = r_main.rm;
    assign set_flags        = r_main.set_flags;
    assign load             = r_main.load;
    assign link             = r_main.link;
    assign illegal          = r_main.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed steps plus random traffic checked against
// a queue-based model of a two-deep in-order buffer with spec-level decode rules.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  opcode;
    logic        immediateOperand;
    logic [11:0] data12;
    logic [23:0] branchOffset;
    logic [3:0]  cond;
    logic [3:0]  rn_addr;
    logic [3:0]  rd_addr;
    logic [3:0]  rm_addr;
    logic        set_flags;
    logic        load;
    logic        link;
    logic        illegal;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    instr_decode_stage #(.PC_WIDTH(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_pc            (in_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .opcode           (opcode),
        .immediateOperand (immediateOperand),
        .data12           (data12),
        .branchOffset     (branchOffset),
        .cond             (cond),
        .rn_addr          (rn_addr),
        .rd_addr          (rd_addr),
        .rm_addr          (rm_addr),
        .set_flags        (set_flags),
        .load             (load),
        .link             (link),
        .illegal          (illegal),
        .out_pc           (out_pc)
    );

    typedef struct {
        logic [61:0] f;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] seen[$];
    bit          log_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          idx;
    bit          acc;

    function automatic logic [61:0] ref_decode(input logic [31:0] w);
        logic [4:0] opc;
        logic       sf, ld, lk, ill, ib;
        opc = 5'b11111; ib = 1'b0; sf = 1'b0; ld = 1'b0; lk = 1'b0; ill = 1'b1;
        if (w[31:28] != 4'hF) begin
            if (w[27:25] == 3'b101) begin
                opc = 5'b10001; ib = w[25]; lk = w[24]; ill = 1'b0;
            end else if (w[27:26] == 2'b01) begin
                opc = 5'b10000; ib = w[25]; ld = w[20]; ill = 1'b0;
            end else if (w[27:26] == 2'b00) begin
                opc = {1'b0, w[24:21]}; ib = w[25]; sf = w[20]; ill = 1'b0;
            end
        end
        return {opc, ib, w[11:0], w[23:0], w[31:28], w[19:16], w[15:12], w[3:0], sf, ld, lk, ill};
    endfunction

    function automatic logic [61:0] obs();
        return {opcode, immediateOperand, data12, branchOffset, cond, rn_addr, rd_addr, rm_addr,
                set_flags, load, link, illegal};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) == 0) w[31:28] = 4'hF;
        else w[31:28] = 4'($urandom_range(0, 14));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_model();
        chk("in_ready", 64'(in_ready), (q.size() < 2) ? 64'd1 : 64'd0);
        chk("out_valid", 64'(out_valid), (q.size() > 0) ? 64'd1 : 64'd0);
        if (q.size() > 0 && out_valid === 1'b1) begin
            chk("fields", 64'(obs()), 64'(q[0].f));
            chk("out_pc", 64'(out_pc), 64'(q[0].pc));
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit a;
        check_model();
        if (log_en && out_valid === 1'b1 && out_ready) seen.push_back(out_pc);
        a = in_valid && (q.size() < 2);
        @(posedge clk);
        if (!reset_n || flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (a) q.push_back('{ref_decode(in_instr), in_pc});
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset held 3 cycles with a word offered.
        reset_n = 1'b0; in_valid = 1'b1; in_instr = 32'hE3A01005; in_pc = 32'h0; out_ready = 1'b1;
        @(negedge clk);
        repeat (3) begin
            chk("rst_fields", 64'(obs()), 64'd0);
            chk("rst_pc", 64'(out_pc), 64'd0);
            cycle();
        end
        reset_n = 1'b1;
        cycle();
        chk("mov", 64'({out_valid, opcode, immediateOperand, rd_addr, data12, cond, illegal}),
            64'({1'b1, 5'b01101, 1'b1, 4'd1, 12'h005, 4'hE, 1'b0}));

        in_instr = 32'hE5912004; in_pc = 32'h4;
        cycle();
        chk("ldr", 64'({out_valid, opcode, immediateOperand, load, rn_addr, rd_addr, data12}),
            64'({1'b1, 5'b10000, 1'b0, 1'b1, 4'd1, 4'd2, 12'h004}));
        in_instr = 32'hEAFFFFFE; in_pc = 32'h8;
        cycle();
        chk("branch", 64'({out_valid, opcode, branchOffset, link, out_pc}),
            64'({1'b1, 5'b10001, 24'hFFFFFE, 1'b0, 32'h8}));
        in_valid = 1'b0;
        repeat (2) cycle();

        // Backpressure: PCs 0,4,8,12 with out_ready low for 4 cycles.
        out_ready = 1'b0; idx = 0; seen.delete(); log_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'(idx * 4);
            acc = (q.size() < 2);
            cycle();
            if (acc) idx++;
        end
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_accepts", 64'(idx), 64'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && idx < 4; k++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'(idx * 4);
            acc = (q.size() < 2);
            cycle();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        repeat (4) cycle();
        log_en = 1'b0;
        chk("bp_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < seen.size(); i++) chk("bp_order", 64'(seen[i]), 64'(i * 4));

        // Flush with main and skid full and a word offered.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hE3A01005; in_pc = 32'h20;
        cycle();
        in_pc = 32'h24;
        cycle();
        flush = 1'b1; in_pc = 32'h40;
        cycle();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; seen.delete(); log_en = 1'b1;
        repeat (3) cycle();
        log_en = 1'b0;
        chk("flush_drop", 64'(seen.size()), 64'd0);

        // Illegal encodings.
        in_valid = 1'b1; in_instr = 32'hEE000000; in_pc = 32'h50;
        cycle();
        chk("illegal_cls", 64'({out_valid, illegal, opcode, set_flags, load, link}),
            64'({1'b1, 1'b1, 5'b11111, 3'b000}));
        in_instr = 32'hF3A01005; in_pc = 32'h54;
        cycle();
        chk("illegal_nv", 64'({out_valid, illegal, opcode, set_flags, load, link, out_pc}),
            64'({1'b1, 1'b1, 5'b11111, 3'b000, 32'h54}));
        in_valid = 1'b0;
        cycle();

        // Random traffic.
        repeat (600) begin
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & ~32'd3;
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset while both registers hold words.
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin
            in_instr = rand_instr(); in_pc = $urandom & ~32'd3;
            cycle();
        end
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_fields", 64'({obs(), out_pc}), 64'd0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1; in_instr = 32'hE5912004; in_pc = 32'h100;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
